// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter.
// memory_op_e : operation presented to the memory (MEM_NOP = no operation).
// arb_state_e : arbiter sequencing states.
// idx_w()     : width of an index into an n-entry vector (minimum 1 bit).
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } memory_op_e;

  localparam int OP_W = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Combinational round-robin selector.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  LG_W     index of the most recent owner
//   pick       out NUM_REQ  one-hot choice: first requester at or after last_grant+1, wrapping
//   valid      out 1        any request present
module rr_picker
  import memory_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LG_W    = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LG_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  logic [NUM_REQ-1:0] upper;
  logic               found;

  // Two passes: requesters above last_grant win first; if none, wrap to the
  // lowest-numbered requester (which may be last_grant itself when it is alone).
  always_comb begin
    upper = '0;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = req[i] && (i > int'(last_grant));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && upper[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between
// NUM_REQ requesters, with per-requester lock for back-to-back transactions
// and a WAIT timeout.
// Handshake: a requester raises req[i] with its op/addr/wdata and holds req
// until done[i] pulses for one cycle; the fields are captured at grant, so
// later changes are ignored. The memory is sent mem_op/mem_addr/mem_wdata from
// the ISSUE cycle and completes by raising mem_ready, sampled in WAIT.
// Ports:
//   clock, reset (async, active high)
//   hold                  blocks new grants
//   req, req_lock         per-requester request / lock
//   req_op/addr/wdata     flattened per-requester fields (requester i at slice i)
//   grant, done, err      one-hot owner, completion pulse, timeout pulse
//   rdata, busy           read result, not-idle flag
//   mem_op/addr/wdata     memory command, mem_rdata/mem_ready memory response
//   arb_state             current FSM state (arb_state_e encoding)
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [7:0]                rdata,
  output logic                      busy,
  output logic [OP_W-1:0]           mem_op,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata,
  input  logic                      mem_ready,
  output logic [1:0]                arb_state
);

  localparam int LG_W = idx_w(NUM_REQ);
  localparam int WC_W = idx_w(TIMEOUT + 1);

  arb_state_e          state;
  logic [LG_W-1:0]     last_grant;
  logic [WC_W-1:0]     wait_cnt;
  logic [OP_W-1:0]     cap_op;

  logic [NUM_REQ-1:0]  pick;
  logic                pick_valid;
  logic [NUM_REQ-1:0]  sel;
  logic [OP_W-1:0]     sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [7:0]          sel_wdata;
  logic [LG_W-1:0]     owner_idx;
  logic                lock_hit;

  rr_picker #(.NUM_REQ(NUM_REQ), .LG_W(LG_W)) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick),
    .valid      (pick_valid)
  );

  // Fields come from the new pick in IDLE, or from the current owner when a
  // locked requester continues from DONE.
  always_comb begin
    sel       = (state == ARB_DONE) ? grant : pick;
    sel_op    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i]) begin
        sel_op    = req_op[i*OP_W +: OP_W];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*8 +: 8];
      end
      if (grant[i]) owner_idx = LG_W'(i);
    end
    lock_hit = |(grant & req & req_lock);
  end

  assign busy      = (state != ARB_IDLE);
  assign arb_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= LG_W'(NUM_REQ - 1);
      wait_cnt   <= '0;
      cap_op     <= MEM_NOP;
      grant      <= '0;
      done       <= '0;
      err        <= 1'b0;
      rdata      <= '0;
      mem_op     <= MEM_NOP;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          mem_op <= MEM_NOP;
          if (!hold && pick_valid) begin
            grant     <= pick;
            cap_op    <= sel_op;
            mem_op    <= sel_op;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (cap_op == MEM_NOP) begin
            done  <= grant;
            state <= ARB_DONE;
          end else begin
            wait_cnt <= '0;
            state    <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_ready) begin
            rdata  <= (cap_op == MEM_READ) ? mem_rdata : 8'h00;
            done   <= grant;
            mem_op <= MEM_NOP;
            state  <= ARB_DONE;
          end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th cycle spent waiting.
            rdata  <= 8'hFF;
            err    <= 1'b1;
            done   <= grant;
            mem_op <= MEM_NOP;
            state  <= ARB_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ARB_DONE: begin
          if (lock_hit) begin
            // Locked owner keeps the port; last_grant untouched, hold ignored.
            cap_op    <= sel_op;
            mem_op    <= sel_op;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            state     <= ARB_ISSUE;
          end else begin
            last_grant <= owner_idx;
            grant      <= '0;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic                      hold;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*8-1:0]      req_wdata;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic [7:0]                rdata;
  logic                      busy;
  logic [OP_W-1:0]           mem_op;
  logic [ADDR_W-1:0]         mem_addr;
  logic [7:0]                mem_wdata;
  logic [7:0]                mem_rdata;
  logic                      mem_ready;
  logic [1:0]                arb_state;

  memory_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .hold      (hold),
    .req       (req),
    .req_lock  (req_lock),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .arb_state (arb_state)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- memory model ----------------
  // Ready arrives mem_lat cycles after the first WAIT cycle; read data is addr ^ 8'hB5.
  int          mem_lat   = 0;
  logic        mem_stuck = 1'b0;
  int          op_cnt    = 0;
  logic [15:0] wr_log[$];

  always @(negedge clock) begin
    if (mem_op != MEM_NOP) op_cnt = op_cnt + 1;
    else op_cnt = 0;
    mem_ready = !mem_stuck && (op_cnt >= 2 + mem_lat);
    mem_rdata = mem_addr ^ 8'hB5;
    if (mem_ready && mem_op == MEM_WRITE) wr_log.push_back({mem_addr, mem_wdata});
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    hold      = 1'b0;
    req       = '0;
    req_lock  = '0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_lat   = 0;
    mem_stuck = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] addr,
                         input logic [7:0] wdata);
    req_op[i*OP_W +: OP_W]      = op;
    req_addr[i*ADDR_W +: ADDR_W] = addr;
    req_wdata[i*8 +: 8]          = wdata;
    req[i]                       = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clock);
      cycles++;
      if (done != '0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #1;
    checks++;
    if ({grant, done, err, rdata, busy, mem_op, mem_addr, mem_wdata, arb_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got grant=%b done=%b err=%b rdata=%h busy=%b op=%0d addr=%h wd=%h st=%0d required all 0",
               grant, done, err, rdata, busy, mem_op, mem_addr, mem_wdata, arb_state);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int cyc;
    apply_reset();
    mem_lat = 2;
    set_req(0, MEM_READ, 8'h10, 8'h00);
    @(negedge clock);
    checks++;
    if (grant !== 2'b01) begin
      failures++; $display("FAIL single_grant: got %b required 01", grant);
    end
    checks++;
    if (mem_op !== MEM_READ || mem_addr !== 8'h10) begin
      failures++; $display("FAIL single_issue: got op=%0d addr=%h required op=1 addr=10", mem_op, mem_addr);
    end
    wait_done("single", 20, cyc);
    checks++;
    if (cyc !== 4) begin
      failures++; $display("FAIL single_latency: got %0d required 4", cyc);
    end
    checks++;
    if (done !== 2'b01 || rdata !== 8'hA5 || err !== 1'b0) begin
      failures++; $display("FAIL single_result: got done=%b rdata=%h err=%b required 01 a5 0", done, rdata, err);
    end
    req[0] = 1'b0;
    @(negedge clock);
    checks++;
    if (done !== 2'b00 || grant !== 2'b00 || arb_state !== ARB_IDLE || rdata !== 8'hA5) begin
      failures++; $display("FAIL single_after: got done=%b grant=%b st=%0d rdata=%h required 00 00 0 a5",
                           done, grant, arb_state, rdata);
    end
  endtask

  task automatic test_contention();
    int cyc;
    logic [1:0] exp_own;
    logic [7:0] exp_rd;
    apply_reset();
    set_req(0, MEM_READ, 8'h30, 8'h00);
    set_req(1, MEM_READ, 8'h31, 8'h00);
    for (int t = 0; t < 4; t++) begin
      exp_own = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_rd  = (t % 2 == 0) ? 8'h85 : 8'h84;
      wait_done("contention", 20, cyc);
      checks++;
      if (done !== exp_own || grant !== exp_own || rdata !== exp_rd) begin
        failures++; $display("FAIL contention_%0d: got done=%b grant=%b rdata=%h required %b %b %h",
                             t, done, grant, rdata, exp_own, exp_own, exp_rd);
      end
      checks++;
      if (cyc !== ((t == 0) ? 3 : 4)) begin
        failures++; $display("FAIL contention_spacing_%0d: got %0d required %0d", t, cyc, (t == 0) ? 3 : 4);
      end
    end
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_lock_burst();
    int cyc;
    logic [15:0] exp_q[$];
    apply_reset();
    wr_log.delete();
    exp_q = '{16'h20B0, 16'h21B1, 16'h22B2};
    req_lock[1] = 1'b1;
    set_req(1, MEM_WRITE, 8'h20, 8'hB0);
    @(negedge clock);
    checks++;
    if (grant !== 2'b10) begin
      failures++; $display("FAIL lock_first_grant: got %b required 10", grant);
    end
    set_req(0, MEM_READ, 8'h40, 8'h00);
    for (int t = 0; t < 3; t++) begin
      wait_done("lock", 20, cyc);
      checks++;
      if (done !== 2'b10 || cyc !== ((t == 0) ? 2 : 3)) begin
        failures++; $display("FAIL lock_burst_%0d: got done=%b spacing=%0d required 10 %0d",
                             t, done, cyc, (t == 0) ? 2 : 3);
      end
      if (t < 2) begin
        req_addr[15:8]  = 8'h21 + 8'(t);
        req_wdata[15:8] = 8'hB1 + 8'(t);
      end else begin
        req_lock[1] = 1'b0;
        req[1]      = 1'b0;
      end
    end
    wait_done("lock_release", 20, cyc);
    checks++;
    if (done !== 2'b01 || rdata !== 8'hF5 || cyc !== 4) begin
      failures++; $display("FAIL lock_release: got done=%b rdata=%h spacing=%0d required 01 f5 4", done, rdata, cyc);
    end
    req[0] = 1'b0;
    checks++;
    if (wr_log.size() != exp_q.size()) begin
      failures++; $display("FAIL lock_writes_count: got %0d required %0d", wr_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_log[i] !== exp_q[i]) begin
          failures++; $display("FAIL lock_write_%0d: got %h required %h", i, wr_log[i], exp_q[i]);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int n_wait;
    int cyc;
    logic seen;
    apply_reset();
    mem_stuck = 1'b1;
    set_req(0, MEM_READ, 8'h11, 8'h00);
    n_wait = 0;
    cyc    = 0;
    seen   = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (arb_state == ARB_WAIT) n_wait++;
      if (done != '0) seen = 1'b1;
    end
    checks++;
    if (!seen || n_wait !== TIMEOUT) begin
      failures++; $display("FAIL timeout_wait_cycles: got seen=%b waits=%0d required 1 %0d", seen, n_wait, TIMEOUT);
    end
    checks++;
    if (done !== 2'b01 || err !== 1'b1 || rdata !== 8'hFF) begin
      failures++; $display("FAIL timeout_result: got done=%b err=%b rdata=%h required 01 1 ff", done, err, rdata);
    end
    req[0] = 1'b0;
    @(negedge clock);
    checks++;
    if (err !== 1'b0 || done !== 2'b00 || arb_state !== ARB_IDLE || busy !== 1'b0) begin
      failures++; $display("FAIL timeout_after: got err=%b done=%b st=%0d busy=%b required 0 00 0 0",
                           err, done, arb_state, busy);
    end
    mem_stuck = 1'b0;
  endtask

  task automatic test_req_drop();
    int cyc;
    apply_reset();
    wr_log.delete();
    mem_lat = 1;
    set_req(0, MEM_WRITE, 8'h55, 8'h33);
    @(negedge clock);
    // Requester drops and scribbles its fields; hold rises mid-transaction.
    req[0]         = 1'b0;
    req_addr[7:0]  = 8'h77;
    req_wdata[7:0] = 8'h99;
    hold           = 1'b1;
    wait_done("drop", 20, cyc);
    checks++;
    if (done !== 2'b01 || rdata !== 8'h00 || cyc !== 3) begin
      failures++; $display("FAIL drop_done: got done=%b rdata=%h cyc=%0d required 01 00 3", done, rdata, cyc);
    end
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== 16'h5533) begin
      failures++; $display("FAIL drop_write: got n=%0d first=%h required 1 5533", wr_log.size(),
                           (wr_log.size() > 0) ? wr_log[0] : 16'h0);
    end
    @(negedge clock);
    hold = 1'b0;
  endtask

  task automatic test_hold_reset();
    int seen_grant;
    int seen_done;
    int cyc;
    apply_reset();
    mem_stuck = 1'b1;
    hold = 1'b1;
    set_req(0, MEM_READ, 8'h12, 8'h00);
    seen_grant = 0;
    repeat (10) begin
      @(negedge clock);
      if (grant != '0 || busy) seen_grant++;
    end
    checks++;
    if (seen_grant !== 0) begin
      failures++; $display("FAIL hold_blocks: got %0d granted cycles required 0", seen_grant);
    end
    hold = 1'b0;
    @(negedge clock);
    checks++;
    if (grant !== 2'b01) begin
      failures++; $display("FAIL hold_release_grant: got %b required 01", grant);
    end
    cyc = 0;
    while (arb_state != ARB_WAIT && cyc < 5) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (arb_state !== ARB_WAIT) begin
      failures++; $display("FAIL hold_reach_wait: got state %0d required 2", arb_state);
    end
    reset = 1'b1;
    req   = '0;
    #1;
    checks++;
    if ({grant, done, err, rdata, busy, mem_op, mem_addr, mem_wdata, arb_state} !== '0) begin
      failures++; $display("FAIL reset_mid_wait: got grant=%b done=%b err=%b rdata=%h busy=%b op=%0d addr=%h st=%0d required all 0",
                           grant, done, err, rdata, busy, mem_op, mem_addr, arb_state);
    end
    @(negedge clock);
    reset     = 1'b0;
    mem_stuck = 1'b0;
    seen_done = 0;
    repeat (3) begin
      @(negedge clock);
      if (done != '0) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++; $display("FAIL reset_no_done: got %0d done cycles required 0", seen_done);
    end
    set_req(0, MEM_READ, 8'h13, 8'h00);
    set_req(1, MEM_READ, 8'h14, 8'h00);
    @(negedge clock);
    checks++;
    if (grant !== 2'b01) begin
      failures++; $display("FAIL reset_first_grant: got %b required 01", grant);
    end
    wait_done("post_reset", 20, cyc);
    req = '0;
    @(negedge clock);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_lock_burst();
    test_timeout();
    test_req_drop();
    test_hold_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
